// File: rtl/tart_bank_scheduler.sv
// tart_bank_scheduler: visibility bank ring with write-bank tracking and full-bank readback streaming.
module tart_bank_scheduler #(
    parameter int BANKS = 4,
    parameter int BBITS = 2,
    parameter int ABITS = 10
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   ce_i,
    input  logic                   swap_i,
    input  logic [ABITS-1:0]       last_i,
    output logic [BBITS-1:0]       wbank_o,
    output logic                   rd_stb_o,
    output logic [BBITS+ABITS-1:0] rd_adr_o,
    input  logic                   rd_ack_i,
    output logic                   done_o,
    output logic [BBITS:0]         fill_o,
    output logic                   busy_o,
    output logic                   ovf_o,
    input  logic                   clr_i
);
    typedef enum logic [1:0] {IDLE, READ, DONE} state_t;
    localparam logic [BBITS:0] FULL = (BBITS+1)'(BANKS-1);
    state_t           state, state_nx;
    logic [BBITS-1:0] rbank;
    logic [ABITS-1:0] addr, addr_nx, last_q, last_nx;
    logic [BBITS:0]   eff_fill;
    logic             take, accept, refuse, rel;
    // A bank released this cycle frees its slot for a coincident swap.
    always_comb begin
        rel      = state == DONE;
        eff_fill = fill_o - (BBITS+1)'(rel);
        take     = swap_i && ce_i;
        accept   = take && eff_fill < FULL;
        refuse   = take && !accept;
        rd_stb_o = state == READ;
        done_o   = rel;
        busy_o   = state != IDLE;
        rd_adr_o = {rbank, addr};
    end
    always_comb begin
        state_nx = state;
        addr_nx  = addr;
        last_nx  = last_q;
        unique case (state)
            IDLE: if (fill_o != '0) begin
                state_nx = READ;
                addr_nx  = '0;
                last_nx  = last_i;
            end
            READ: if (rd_ack_i) begin
                if (addr == last_q) state_nx = DONE;
                else addr_nx = addr + 1'b1;
            end
            DONE: begin
                state_nx = IDLE;
                addr_nx  = '0;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            addr    <= '0;
            last_q  <= '0;
            rbank   <= '0;
            wbank_o <= '0;
            fill_o  <= '0;
            ovf_o   <= 1'b0;
        end else begin
            state   <= state_nx;
            addr    <= addr_nx;
            last_q  <= last_nx;
            rbank   <= rbank + BBITS'(rel);
            wbank_o <= wbank_o + BBITS'(accept);
            fill_o  <= fill_o + (BBITS+1)'(accept) - (BBITS+1)'(rel);
            ovf_o   <= refuse | (ovf_o & ~clr_i);
        end
    end
endmodule
